freq_divider_prog: RTL and testbench

Multi-channel, runtime-programmable clock-enable/divided-clock generator; successor to the fixed-ratio single-output divider. Each channel produces a duty-programmable divided level (clk_o) and a one-cycle period strobe (stb_o) from the single system clock. Divisor and high-time are reloaded through a valid/ready config port with glitch-free, period-boundary update. A shared sync input phase-aligns all channels. It sits beside peripheral controllers (UART/SPI/PWM timing) as their common tick source.

---
 rtl/freq_divider_prog_if.sv | 23 ++
 rtl/freq_divider_prog.sv | 135 +++++++++++++
 tb/tb_freq_divider_prog.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/freq_divider_prog_if.sv
// Configuration port of freq_divider_prog: valid/ready reload of one channel's
// divisor and high-time, plus a one-cycle rejection pulse.
interface freq_divider_prog_if #(
  parameter int CH_WIDTH  = 1,
  parameter int DIV_WIDTH = 8
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_WIDTH-1:0]  cfg_ch;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] cfg_high;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/freq_divider_prog.sv
// Multi-channel programmable divider: per-channel divided level and period strobe,
// with shadowed divisor/high-time that take effect only on a period boundary.
module freq_divider_prog #(
  parameter  int CHANNELS     = 2,
  parameter  int DIV_WIDTH    = 8,
  parameter  int DEFAULT_DIV  = 2,
  parameter  int DEFAULT_HIGH = 1,
  localparam int CH_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                a_rst_n_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                sync_i,
  freq_divider_prog_if.slave  cfg,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] stb_o
);

  typedef logic [DIV_WIDTH-1:0] cnt_t;

  cnt_t cnt_q   [CHANNELS];
  cnt_t cnt_d   [CHANNELS];
  cnt_t div_q   [CHANNELS];
  cnt_t div_d   [CHANNELS];
  cnt_t high_q  [CHANNELS];
  cnt_t high_d  [CHANNELS];
  cnt_t sdiv_q  [CHANNELS];
  cnt_t sdiv_d  [CHANNELS];
  cnt_t shigh_q [CHANNELS];
  cnt_t shigh_d [CHANNELS];

  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] stb_q, stb_d;
  logic                err_q, err_d;

  logic ch_in_range;
  logic xfer;
  logic bad_req;
  logic accept;
  logic wrap;
  logic restart;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      run_q  <= '0;
      pend_q <= '0;
      clk_q  <= '0;
      stb_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= '0;
        div_q[i]   <= cnt_t'(DEFAULT_DIV);
        high_q[i]  <= cnt_t'(DEFAULT_HIGH);
        sdiv_q[i]  <= cnt_t'(DEFAULT_DIV);
        shigh_q[i] <= cnt_t'(DEFAULT_HIGH);
      end
    end else begin
      run_q  <= run_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      stb_q  <= stb_d;
      err_q  <= err_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        high_q[i]  <= high_d[i];
        sdiv_q[i]  <= sdiv_d[i];
        shigh_q[i] <= shigh_d[i];
      end
    end
  end

  // An out-of-range channel is still handshaked so the request can be rejected.
  always_comb begin
    ch_in_range   = (32'(cfg.cfg_ch) < CHANNELS);
    cfg.cfg_ready = 1'b1;
    if (ch_in_range) cfg.cfg_ready = !pend_q[cfg.cfg_ch];
    xfer    = cfg.cfg_valid && cfg.cfg_ready;
    bad_req = (cfg.cfg_div == '0) || !ch_in_range;
    accept  = xfer && !bad_req;
    err_d   = xfer && bad_req;
  end

  always_comb begin
    run_d  = run_q;
    pend_d = pend_q;
    clk_d  = '0;
    stb_d  = '0;
    wrap    = 1'b0;
    restart = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      high_d[i]  = high_q[i];
      sdiv_d[i]  = sdiv_q[i];
      shigh_d[i] = shigh_q[i];

      wrap    = (cnt_q[i] == div_q[i] - cnt_t'(1));
      restart = !run_q[i] || sync_i || wrap;

      if (!en_i[i]) begin
        run_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else if (restart) begin
        run_d[i] = 1'b1;
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end

      // Every restart or disabled cycle is a period boundary, so shadows land cleanly.
      if ((!en_i[i] || restart) && pend_q[i]) begin
        div_d[i]  = sdiv_q[i];
        high_d[i] = shigh_q[i];
        pend_d[i] = 1'b0;
      end

      if (accept && (cfg.cfg_ch == CH_WIDTH'(i))) begin
        sdiv_d[i]  = cfg.cfg_div;
        shigh_d[i] = cfg.cfg_high;
        pend_d[i]  = 1'b1;
      end

      clk_d[i] = run_d[i] && (cnt_d[i] < high_d[i]);
      stb_d[i] = run_d[i] && (cnt_d[i] == '0);
    end
  end

  assign clk_o       = clk_q;
  assign stb_o       = stb_q;
  assign cfg.cfg_err = err_q;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Randomized and directed bench for freq_divider_prog with a period-level
// reference model feeding a scoreboard queue.
module tb_freq_divider_prog;
  localparam int CH  = 3;
  localparam int DW  = 8;
  localparam int CHW = 2;

  typedef struct {
    logic [CH-1:0] clk;
    logic [CH-1:0] stb;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic          sync = 1'b0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] stb_out;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  int m_run [CH];
  int m_pos [CH];
  int m_div [CH];
  int m_high[CH];
  int m_pend[CH];
  int m_sdiv[CH];
  int m_shigh[CH];

  freq_divider_prog_if #(.CH_WIDTH(CHW), .DIV_WIDTH(DW)) cfg_if ();

  freq_divider_prog #(
    .CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(2), .DEFAULT_HIGH(1)
  ) dut (
    .clk_i(clk), .a_rst_n_i(rst_n), .en_i(en), .sync_i(sync),
    .cfg(cfg_if.slave), .clk_o(clk_out), .stb_o(stb_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_pend[i] = 0;
      m_div[i] = 2; m_high[i] = 1; m_sdiv[i] = 2; m_shigh[i] = 1;
    end
  endtask

  // One clock of the reference: position within the period, applied on boundaries.
  task automatic model_step(input logic [CH-1:0] e_en, input logic sy, input logic v,
                            input int ch, input int d, input int h, output exp_t e);
    int  rdy;
    bit  xfer, bad, boundary;
    rdy  = (ch >= CH) ? 1 : (m_pend[ch] == 0);
    xfer = v && (rdy != 0);
    bad  = (d == 0) || (ch >= CH);
    e.err = xfer && bad;
    for (int i = 0; i < CH; i++) begin
      if (!e_en[i]) begin
        m_run[i] = 0; m_pos[i] = 0; boundary = 1;
      end else if (m_run[i] == 0 || sy) begin
        m_run[i] = 1; m_pos[i] = 0; boundary = 1;
      end else begin
        m_pos[i] = (m_pos[i] + 1) % m_div[i];
        boundary = (m_pos[i] == 0);
      end
      if (boundary && m_pend[i] != 0) begin
        m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
      end
      if (xfer && !bad && ch == i) begin
        m_sdiv[i] = d; m_shigh[i] = h; m_pend[i] = 1;
      end
      e.clk[i] = (m_run[i] != 0) && (m_pos[i] < m_high[i]);
      e.stb[i] = (m_run[i] != 0) && (m_pos[i] == 0);
    end
  endtask

  task automatic cycle(input logic [CH-1:0] e_en, input logic sy, input logic v,
                       input logic [CHW-1:0] ch, input logic [DW-1:0] d, input logic [DW-1:0] h);
    exp_t e;
    int   exp_rdy;
    @(negedge clk);
    en = e_en; sync = sy;
    cfg_if.cfg_valid = v; cfg_if.cfg_ch = ch; cfg_if.cfg_div = d; cfg_if.cfg_high = h;
    #1;
    exp_rdy = (int'(ch) >= CH) ? 1 : (m_pend[int'(ch)] == 0);
    chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(exp_rdy));
    model_step(e_en, sy, v, int'(ch), int'(d), int'(h), e);
    sb.push_back(e);
  endtask

  task automatic idle(input logic [CH-1:0] e_en, input int n);
    for (int k = 0; k < n; k++) cycle(e_en, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("clk_o", 32'(clk_out), 32'(e.clk));
        chk("stb_o", 32'(stb_out), 32'(e.stb));
        chk("cfg_err", 32'(cfg_if.cfg_err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [CH-1:0] ren;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_high = '0;
    model_reset();
    #12;
    chk("reset clk_o", 32'(clk_out), 32'd0);
    chk("reset stb_o", 32'(stb_out), 32'd0);
    chk("reset cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults on ch0
    idle(3'b001, 8);
    // Reprogram mid-period, second write blocked while pending
    cycle(3'b001, 1'b0, 1'b1, 2'd0, 8'd5, 8'd2);
    cycle(3'b001, 1'b0, 1'b1, 2'd0, 8'd7, 8'd3);
    idle(3'b001, 14);
    // Illegal requests
    cycle(3'b001, 1'b0, 1'b1, 2'd1, 8'd0, 8'd3);
    cycle(3'b001, 1'b0, 1'b1, 2'd3, 8'd4, 8'd1);
    idle(3'b001, 3);
    // Duty extremes
    cycle(3'b001, 1'b0, 1'b1, 2'd1, 8'd3, 8'd0);
    cycle(3'b001, 1'b0, 1'b1, 2'd2, 8'd4, 8'd7);
    cycle(3'b001, 1'b0, 1'b1, 2'd0, 8'd1, 8'd1);
    idle(3'b111, 14);
    // Sync alignment
    cycle(3'b011, 1'b0, 1'b1, 2'd0, 8'd3, 8'd1);
    cycle(3'b011, 1'b0, 1'b1, 2'd1, 8'd4, 8'd2);
    idle(3'b011, 9);
    cycle(3'b011, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
    idle(3'b011, 10);
    // Async reset with a pending write on ch1 while ch0 strobes every cycle
    cycle(3'b011, 1'b0, 1'b1, 2'd0, 8'd1, 8'd1);
    idle(3'b011, 5);
    cycle(3'b011, 1'b0, 1'b1, 2'd1, 8'd7, 8'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst clk_o", 32'(clk_out), 32'd0);
    chk("async rst stb_o", 32'(stb_out), 32'd0);
    en = '0; sync = 1'b0; cfg_if.cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(3'b000, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0);
    idle(3'b011, 8);

    // Randomized traffic
    ren = 3'b111;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 99) < 4) ren[i] = ~ren[i];
      cycle(ren, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 40),
            CHW'($urandom_range(0, 3)), DW'($urandom_range(0, 9)), DW'($urandom_range(0, 10)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
